// File: rtl/sc_stream_counter.sv
// -----------------------------------------------------------------------------
// sc_stream_counter
//   Stochastic-to-binary decoder. It counts the ones in one fixed-length
//   window of a stochastic bitstream and returns the count as an unsigned word.
//   One window is one LFSR period of the generator that feeds the stream.
//
// Parameters
//   DATA_W      width of the result and of the internal counters
//   STREAM_LEN  bits per window, 1 <= STREAM_LEN <= 2^DATA_W-1
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous reset, ACTIVE-HIGH despite the name
//   start         begin a new window (accepted only in IDLE)
//   bit_in        stream bit, sampled when bit_valid=1 in ACCUM
//   bit_valid     qualifies bit_in
//   busy          high in ACCUM or DONE
//   result        count of ones in the last completed window
//   result_valid  result holds a new value, held until result_ready
//   result_ready  consumer accepts result on result_valid & result_ready
//   state_dbg     current FSM state (debug only)
//   abort         (only with SC_ABORT_EN) drop the current window in ACCUM
//
// Handshake: result transfers on a rising edge where result_valid and
// result_ready are both high. Once result_valid rises, result and
// result_valid stay unchanged until that edge.
//
// Optional feature macro: SC_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module sc_stream_counter #(
  parameter int DATA_W     = 8,
  parameter int STREAM_LEN = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
`ifdef SC_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // len_cnt value just before the final bit of the window is accepted.
  localparam logic [DATA_W-1:0] LAST_IDX = DATA_W'(STREAM_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] ones_q, ones_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  logic              abort_w;
  logic [DATA_W-1:0] bit_ext;

`ifdef SC_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign bit_ext = {{(DATA_W-1){1'b0}}, bit_in};

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    len_d    = len_q;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ones_d  = '0;
          len_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // Abort wins over a simultaneous final-bit accept.
        if (abort_w) begin
          ones_d  = '0;
          len_d   = '0;
          state_d = S_IDLE;
        end else if (bit_valid) begin
          len_d  = len_q + 1'b1;
          ones_d = ones_q + bit_ext;
          if (len_q == LAST_IDX) begin
            result_d = ones_q + bit_ext;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start in the handshake cycle is simply not looked at here.
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      ones_q   <= '0;
      len_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      len_q    <= len_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state_dbg    = state_q;

endmodule
